datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 189 ++++++++++++++++++
 tb/tb_datapath.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Multi-cycle 64-bit datapath: PC/IR/MDR/A/B/ALUOut, a 32x64 register file and a unified
// 4 KiB memory, all steered by externally supplied control signals.
module datapath (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ALUOp,
    input  logic       MemtoReg,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic       IorD,
    input  logic       RegWrite,
    input  logic       IRWrite,
    input  logic       PCWrite,
    input  logic       PCWriteCond,
    input  logic       ALUSrcA,
    input  logic [1:0] ALUSrcB,
    input  logic       PCSource,
    output logic [6:0] opcode
);

    localparam int unsigned MemWords = 512;
    localparam int unsigned NumRegs  = 32;

    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSd  = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b0100011;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSlt
    } alu_op_e;

    // Architectural state
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [63:0] mdr_q, mdr_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] alu_out_q, alu_out_d;
    logic [63:0] rf_q [NumRegs];
    logic [63:0] mem [MemWords];

    // Instruction fields
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        funct7_b5;

    // Memory access
    logic [63:0] mem_addr;
    logic [8:0]  mem_idx;
    logic [63:0] mem_rdata;
    logic [31:0] fetch_word;
    logic        unused_addr_bits;

    // ALU
    logic [11:0] imm12;
    logic [63:0] imm;
    logic [63:0] src_a, src_b;
    alu_op_e     alu_op;
    logic [63:0] alu_result;
    logic        zero;

    // Register write-back
    logic        rf_we;
    logic [63:0] rf_wdata;

    assign opcode    = ir_q[6:0];
    assign rd        = ir_q[11:7];
    assign funct3    = ir_q[14:12];
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign funct7_b5 = ir_q[30];

    assign mem_addr   = IorD ? alu_out_q : pc_q;
    assign mem_idx    = mem_addr[11:3];
    assign mem_rdata  = mem[mem_idx];
    assign fetch_word = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    // Only doubleword index and fetch half-select are decoded; the rest is don't-care.
    assign unused_addr_bits = ^{mem_addr[63:12], mem_addr[1:0]};

    always_comb begin
        imm12 = '0;
        case (opcode)
            OpLd:    imm12 = ir_q[31:20];
            OpSd:    imm12 = {ir_q[31:25], ir_q[11:7]};
            OpBeq:   imm12 = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
            default: imm12 = '0;
        endcase
    end

    assign imm = {{52{imm12[11]}}, imm12};

    always_comb begin
        src_a = ALUSrcA ? a_q : pc_q;
        src_b = b_q;
        case (ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = 64'd4;
            2'b10:   src_b = imm;
            default: src_b = {imm[62:0], 1'b0};
        endcase
    end

    always_comb begin
        alu_op = AluAdd;
        case (ALUOp)
            2'b01: alu_op = AluSub;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_op = funct7_b5 ? AluSub : AluAdd;
                    3'b111:  alu_op = AluAnd;
                    3'b110:  alu_op = AluOr;
                    3'b100:  alu_op = AluXor;
                    3'b010:  alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
            end
            default: alu_op = AluAdd;
        endcase
    end

    always_comb begin
        alu_result = src_a + src_b;
        case (alu_op)
            AluSub:  alu_result = src_a - src_b;
            AluAnd:  alu_result = src_a & src_b;
            AluOr:   alu_result = src_a | src_b;
            AluXor:  alu_result = src_a ^ src_b;
            AluSlt:  alu_result = {63'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = src_a + src_b;
        endcase
    end

    assign zero = (alu_result == 64'd0);

    always_comb begin
        ir_d      = IRWrite ? fetch_word : ir_q;
        mdr_d     = MemRead ? mem_rdata : 64'd0;
        a_d       = (rs1 == 5'd0) ? 64'd0 : rf_q[rs1];
        b_d       = (rs2 == 5'd0) ? 64'd0 : rf_q[rs2];
        alu_out_d = alu_result;
        pc_d      = pc_q;
        if (PCWrite || (PCWriteCond && zero)) begin
            pc_d = PCSource ? alu_out_q : alu_result;
        end
    end

    always_comb begin
        rf_we    = RegWrite && (rd != 5'd0);
        rf_wdata = MemtoReg ? mdr_q : alu_out_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            if (rf_we) begin
                rf_q[rd] <= rf_wdata;
            end
        end
    end

    // Memory has no reset; a store still lands when MemRead is also (erroneously) high.
    always_ff @(posedge clock) begin
        if (!reset && MemWrite) begin
            mem[mem_idx] <= b_q;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: an architectural model is stepped with the stimulus and
// compared against the DUT every cycle; literal checks pin the key results.
module tb_datapath;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] ALUOp;
    logic       MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite;
    logic       PCWrite, PCWriteCond, ALUSrcA, PCSource;
    logic [1:0] ALUSrcB;
    logic [6:0] opcode;

    datapath dut (
        .clock      (clock),
        .reset      (reset),
        .ALUOp      (ALUOp),
        .MemtoReg   (MemtoReg),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .opcode     (opcode)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic [1:0] aluop;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       pcsource;
    } ctrl_t;

    localparam ctrl_t CIdle   = '0;
    localparam ctrl_t CReset  = '{rst: 1'b1, default: '0};
    localparam ctrl_t CFetch  = '{memread: 1'b1, irwrite: 1'b1, pcwrite: 1'b1,
                                  alusrcb: 2'b01, default: '0};
    localparam ctrl_t CFetch3 = '{memread: 1'b1, irwrite: 1'b1, pcwrite: 1'b1,
                                  alusrcb: 2'b01, aluop: 2'b11, default: '0};
    localparam ctrl_t CRAlu   = '{alusrca: 1'b1, aluop: 2'b10, default: '0};
    localparam ctrl_t CRWb    = '{regwrite: 1'b1, default: '0};
    localparam ctrl_t CAddr   = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
    localparam ctrl_t CMemRd  = '{iord: 1'b1, memread: 1'b1, default: '0};
    localparam ctrl_t CLdWb   = '{regwrite: 1'b1, memtoreg: 1'b1, default: '0};
    localparam ctrl_t CMemWr  = '{iord: 1'b1, memwrite: 1'b1, default: '0};
    localparam ctrl_t CBrTgt  = '{alusrcb: 2'b11, default: '0};
    localparam ctrl_t CBr     = '{alusrca: 1'b1, aluop: 2'b01, pcwritecond: 1'b1,
                                  pcsource: 1'b1, default: '0};
    localparam ctrl_t CMidRst = '{rst: 1'b1, regwrite: 1'b1, memwrite: 1'b1, iord: 1'b1,
                                  pcwrite: 1'b1, irwrite: 1'b1, default: '0};

    localparam logic [31:0] InsAdd   = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] InsSub   = 32'h402081B3;  // sub x3,x1,x2
    localparam logic [31:0] InsLd    = 32'h0080B283;  // ld x5,8(x1)
    localparam logic [31:0] InsSd    = 32'h00203813;  // store x2 -> 16(x0)
    localparam logic [31:0] InsBeq   = 32'h00208423;  // beq x1,x2,imm=4
    localparam logic [31:0] InsAddX0 = 32'h00208033;  // add x0,x1,x2

    // Architectural model
    logic [63:0] m_pc, m_mdr, m_a, m_b, m_alu;
    logic [31:0] m_ir;
    logic [63:0] m_rf [32];
    logic [63:0] m_mem [512];

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ir);
        case (ir[6:0])
            7'b0000011: return sext12(ir[31:20]);
            7'b0010011: return sext12({ir[31:25], ir[11:7]});
            7'b0100011: return sext12({ir[31], ir[7], ir[30:25], ir[11:8]});
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] model_alu(input logic [1:0] cls, input logic [31:0] ir,
                                              input logic [63:0] x, input logic [63:0] y);
        longint sx, sy;
        sx = x;
        sy = y;
        if (cls == 2'b01) return x - y;
        if (cls != 2'b10) return x + y;
        case (ir[14:12])
            3'b000:  return ir[30] ? x - y : x + y;
            3'b111:  return x & y;
            3'b110:  return x | y;
            3'b100:  return x ^ y;
            3'b010:  return (sx < sy) ? 64'd1 : 64'd0;
            default: return x + y;
        endcase
    endfunction

    // Advance the model by one clock edge under control c (all reads use pre-edge state).
    task automatic model_edge(input ctrl_t c);
        logic [63:0] addr, word, opa, opb, res, wb, na, nb, nmdr, npc;
        logic [31:0] nir;
        if (c.rst) begin
            m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        addr = c.iord ? m_alu : m_pc;
        word = m_mem[addr[11:3]];
        opa  = c.alusrca ? m_a : m_pc;
        case (c.alusrcb)
            2'b00:   opb = m_b;
            2'b01:   opb = 64'd4;
            2'b10:   opb = model_imm(m_ir);
            default: opb = model_imm(m_ir) * 2;
        endcase
        res  = model_alu(c.aluop, m_ir, opa, opb);
        wb   = c.memtoreg ? m_mdr : m_alu;
        na   = m_rf[m_ir[19:15]];
        nb   = m_rf[m_ir[24:20]];
        nmdr = c.memread ? word : 64'd0;
        nir  = c.irwrite ? (addr[2] ? word[63:32] : word[31:0]) : m_ir;
        npc  = m_pc;
        if (c.pcwrite || (c.pcwritecond && res == 64'd0)) npc = c.pcsource ? m_alu : res;
        if (c.memwrite) m_mem[addr[11:3]] = m_b;
        if (c.regwrite && m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] = wb;
        m_pc = npc; m_ir = nir; m_mdr = nmdr; m_a = na; m_b = nb; m_alu = res;
    endtask

    task automatic step(input ctrl_t c);
        reset       = c.rst;
        ALUOp       = c.aluop;
        MemtoReg    = c.memtoreg;
        MemRead     = c.memread;
        MemWrite    = c.memwrite;
        IorD        = c.iord;
        RegWrite    = c.regwrite;
        IRWrite     = c.irwrite;
        PCWrite     = c.pcwrite;
        PCWriteCond = c.pcwritecond;
        ALUSrcA     = c.alusrca;
        ALUSrcB     = c.alusrcb;
        PCSource    = c.pcsource;
        model_edge(c);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic poke_rf(input int r, input logic [63:0] v);
        dut.rf_q[r] <= v;
        m_rf[r] = v;
    endtask

    task automatic poke_dword(input int idx, input logic [63:0] v);
        dut.mem[idx] <= v;
        m_mem[idx] = v;
    endtask

    task automatic poke_word(input logic [63:0] addr, input logic [31:0] w);
        logic [63:0] d;
        d = m_mem[addr[11:3]];
        if (addr[2]) d[63:32] = w;
        else d[31:0] = w;
        poke_dword(int'(addr[11:3]), d);
    endtask

    // Per-cycle comparison of all architectural state against the model.
    always begin
        @(posedge clock);
        #2;
        if (chk_en) begin
            int bad;
            chk("pc", dut.pc_q, m_pc);
            chk("ir", {32'd0, dut.ir_q}, {32'd0, m_ir});
            chk("opcode", {57'd0, opcode}, {57'd0, m_ir[6:0]});
            chk("mdr", dut.mdr_q, m_mdr);
            chk("a", dut.a_q, m_a);
            chk("b", dut.b_q, m_b);
            chk("aluout", dut.alu_out_q, m_alu);
            for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut.rf_q[i], m_rf[i]);
            bad = -1;
            for (int i = 0; i < 512; i++) if (bad < 0 && dut.mem[i] !== m_mem[i]) bad = i;
            chk("mem_first_bad_idx", 64'(bad), 64'hFFFF_FFFF_FFFF_FFFF);
        end
    end

    logic [2:0]  f3_tab  [5] = '{3'b111, 3'b110, 3'b100, 3'b010, 3'b001};
    logic [63:0] exp_tab [5] = '{64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB,
                                 64'd1, 64'd3};

    initial begin
        step_inputs_zero: begin
            reset = 1'b0; ALUOp = '0; MemtoReg = 0; MemRead = 0; MemWrite = 0; IorD = 0;
            RegWrite = 0; IRWrite = 0; PCWrite = 0; PCWriteCond = 0; ALUSrcA = 0;
            ALUSrcB = '0; PCSource = 0;
        end
        m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        for (int i = 0; i < 512; i++) poke_dword(i, 64'd0);
        poke_word(64'd0, InsAdd);
        poke_word(64'd4, InsSub);

        // Reset and fetch
        step(CReset);
        chk_en = 1'b1;
        chk("rst_pc", dut.pc_q, 64'd0);
        chk("rst_opcode", {57'd0, opcode}, 64'd0);
        step(CFetch);
        chk("fetch_ir", {32'd0, dut.ir_q}, {32'd0, InsAdd});
        chk("fetch_opcode", {57'd0, opcode}, 64'h33);
        chk("fetch_pc", dut.pc_q, 64'd4);
        chk("model_fetch_pc", m_pc, 64'd4);

        // R-type add, then sub from the upper half of the same doubleword
        poke_rf(1, 64'd5);
        poke_rf(2, 64'd7);
        step(CIdle); step(CRAlu);
        chk("add_aluout", dut.alu_out_q, 64'd12);
        step(CRWb);
        chk("add_x3", dut.rf_q[3], 64'd12);
        chk("model_add_x3", m_rf[3], 64'd12);
        step(CFetch); step(CIdle); step(CRAlu); step(CRWb);
        chk("sub_x3", dut.rf_q[3], 64'hFFFF_FFFF_FFFF_FFFE);

        // Load
        poke_word(64'd8, InsLd);
        poke_word(64'd12, InsSd);
        poke_dword(2, 64'h1122_3344_5566_7788);
        poke_rf(1, 64'd8);
        step(CFetch); step(CIdle); step(CAddr);
        chk("ld_addr", dut.alu_out_q, 64'd16);
        step(CMemRd); step(CLdWb);
        chk("ld_x5", dut.rf_q[5], 64'h1122_3344_5566_7788);
        chk("model_ld_x5", m_rf[5], 64'h1122_3344_5566_7788);

        // Store
        poke_rf(2, 64'hDEAD);
        step(CFetch); step(CIdle); step(CAddr); step(CMemWr);
        chk("sd_mem2", dut.mem[2], 64'hDEAD);
        chk("model_sd_mem2", m_mem[2], 64'hDEAD);

        // Branch taken (x1 == x2 == 0 after reset)
        poke_word(64'd0, InsBeq);
        poke_word(64'd4, InsAddX0);
        step(CReset); step(CFetch); step(CBrTgt);
        chk("br_target", dut.alu_out_q, 64'd12);
        step(CBr);
        chk("br_taken_pc", dut.pc_q, 64'd12);

        // Branch not taken
        step(CReset);
        poke_rf(1, 64'd3);
        step(CFetch); step(CBrTgt); step(CBr);
        chk("br_not_taken_pc", dut.pc_q, 64'd4);

        // x0 write ignored, then reset mid-sequence with writes requested
        poke_rf(2, 64'h55);
        step(CFetch); step(CIdle); step(CRAlu); step(CRWb);
        chk("x0_ignored", dut.rf_q[0], 64'd0);
        step(CRAlu);
        step(CMidRst);
        chk("midrst_pc", dut.pc_q, 64'd0);
        chk("midrst_x1", dut.rf_q[1], 64'd0);
        chk("midrst_aluout", dut.alu_out_q, 64'd0);
        chk("midrst_mem2", dut.mem[2], 64'hDEAD);
        chk("midrst_mem11", dut.mem[11], 64'd0);

        // Decoded ALU operations with signed operands; fetch uses ALUOp=11
        poke_rf(1, 64'hFFFF_FFFF_FFFF_FFFD);
        poke_rf(2, 64'd6);
        for (int k = 0; k < 5; k++) begin
            poke_word(m_pc, InsAdd | (32'(f3_tab[k]) << 12));
            step(CFetch3); step(CIdle); step(CRAlu); step(CRWb);
            chk($sformatf("alu_f3_%0d_x3", f3_tab[k]), dut.rf_q[3], exp_tab[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
